// File: rtl/out_port_buf_if.sv
// ---------------------------------------------------------------------------
// out_port_buf_if
//   Bundles the arbiter-side and link-side signals of one router output port.
//
//   Arbiter / input buffer side:
//     gnt         [4:0]      one-hot grant, [4]=N [3]=S [2]=E [1]=W [0]=PE
//     din_n/s/e/w/pe         head flits of the five input buffers
//     in_pop      [4:0]      pop strobes back to the input buffers
//     outbuf_full            FIFO full, blocks further grants
//   Link side:
//     so / dout / ri         send-valid, link data, downstream ready
//   Status:
//     count       [AW:0]     FIFO occupancy
//     err                    sticky protocol error (only with OUTBUF_ERR_EN)
//
//   Link handshake: a flit moves on a rising edge where so=1 and ri=1; while
//   ri=0 the sender keeps so high and dout stable (no retraction).
//
//   Modports: master = upstream driver (arbiter/input buffers/link sink),
//             slave  = the out_port_buf block.
// ---------------------------------------------------------------------------
interface out_port_buf_if #(
    parameter int DATA_W = 64,
    parameter int AW     = 1
);
    logic [4:0]        gnt;
    logic [DATA_W-1:0] din_n;
    logic [DATA_W-1:0] din_s;
    logic [DATA_W-1:0] din_e;
    logic [DATA_W-1:0] din_w;
    logic [DATA_W-1:0] din_pe;
    logic [4:0]        in_pop;
    logic              outbuf_full;
    logic              so;
    logic [DATA_W-1:0] dout;
    logic              ri;
    logic [AW:0]       count;
`ifdef OUTBUF_ERR_EN
    logic              err;

    modport master (
        output gnt, din_n, din_s, din_e, din_w, din_pe, ri,
        input  in_pop, outbuf_full, so, dout, count, err
    );
    modport slave (
        input  gnt, din_n, din_s, din_e, din_w, din_pe, ri,
        output in_pop, outbuf_full, so, dout, count, err
    );
`else
    modport master (
        output gnt, din_n, din_s, din_e, din_w, din_pe, ri,
        input  in_pop, outbuf_full, so, dout, count
    );
    modport slave (
        input  gnt, din_n, din_s, din_e, din_w, din_pe, ri,
        output in_pop, outbuf_full, so, dout, count
    );
`endif
endinterface

// File: rtl/out_port_buf.sv
// ---------------------------------------------------------------------------
// out_port_buf
//   Output stage of one router port. The flit picked by the arbiter's one-hot
//   grant is written into a DEPTH-entry FIFO; the FIFO head drives the
//   inter-router link with a send/ready handshake.
//
//   Ports:
//     clk     rising-edge clock
//     reset   synchronous, active-high; clears pointers/occupancy (and err)
//     bus     out_port_buf_if.slave (gnt, din_*, in_pop, outbuf_full,
//             so, dout, ri, count, err)
//
//   Optional feature: define OUTBUF_ERR_EN to add the sticky bus.err flag,
//   set by a non-one-hot grant or by any grant while the FIFO is full.
// ---------------------------------------------------------------------------
module out_port_buf #(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 2,
    parameter int AW     = 1
) (
    input  logic           clk,
    input  logic           reset,
    out_port_buf_if.slave  bus
);

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [AW:0]       count_q,  count_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] mem_d [DEPTH];

    logic [DATA_W-1:0] sel;
    logic              full;
    logic              push;
    logic              pop;

    // Full comes only from registered occupancy so the arbiter's grant can
    // depend on it without forming a combinational loop.
    assign full = (count_q == (AW+1)'(DEPTH));

    // AND-OR mux: for a legal one-hot grant this is the granted flit.
    always_comb begin
        sel = ({DATA_W{bus.gnt[4]}} & bus.din_n)
            | ({DATA_W{bus.gnt[3]}} & bus.din_s)
            | ({DATA_W{bus.gnt[2]}} & bus.din_e)
            | ({DATA_W{bus.gnt[1]}} & bus.din_w)
            | ({DATA_W{bus.gnt[0]}} & bus.din_pe);
    end

    assign push = (bus.gnt != 5'd0) && !full;
    assign pop  = (count_q != '0) && bus.ri;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = sel;
            wr_ptr_d        = wr_ptr_q + AW'(1);   // wraps at DEPTH (power of two)
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign bus.in_pop      = push ? bus.gnt : 5'd0;
    assign bus.outbuf_full = full;
    assign bus.so          = (count_q != '0);
    assign bus.dout        = mem_q[rd_ptr_q];
    assign bus.count       = count_q;

`ifdef OUTBUF_ERR_EN
    logic err_q, err_d;
    logic gnt_multi;

    // More than one grant bit set: clearing the lowest set bit leaves non-zero.
    assign gnt_multi = ((bus.gnt & (bus.gnt - 5'd1)) != 5'd0);

    always_comb begin
        err_d = err_q;
        if ((bus.gnt != 5'd0) && (gnt_multi || full)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign bus.err = err_q;
`endif

endmodule

// File: tb/tb_out_port_buf.sv
// ---------------------------------------------------------------------------
// tb_out_port_buf
//   Drives out_port_buf through directed scenarios and a randomized phase,
//   comparing every cycle against a queue-based model of the output FIFO.
// ---------------------------------------------------------------------------
module tb_out_port_buf;

    localparam int DATA_W = 64;
    localparam int DEPTH  = 2;
    localparam int AW     = 1;

    logic clk;
    logic reset;

    logic [4:0]        gnt;
    logic              ri;
    logic [DATA_W-1:0] din [5];   // index = grant bit: 0=PE 1=W 2=E 3=S 4=N

    out_port_buf_if #(.DATA_W(DATA_W), .AW(AW)) bus ();

    assign bus.gnt    = gnt;
    assign bus.ri     = ri;
    assign bus.din_pe = din[0];
    assign bus.din_w  = din[1];
    assign bus.din_e  = din[2];
    assign bus.din_s  = din[3];
    assign bus.din_n  = din[4];

    out_port_buf #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] exp_q[$];
    logic              exp_err;
    int                n_checks;
    int                n_pass;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // One clock: apply inputs, check outputs mid-cycle, then advance the model
    // at the rising edge. Inputs are applied 1 time unit after a rising edge.
    task automatic drive_cycle(input logic [4:0] g, input logic r, input logic rst);
        int                sz;
        logic [DATA_W-1:0] flit;
        logic [4:0]        exp_pop;
        gnt   = g;
        ri    = r;
        reset = rst;
        @(negedge clk);
        sz      = exp_q.size();
        exp_pop = (g != 5'd0 && sz < DEPTH) ? g : 5'd0;
        check("so",          bus.so,          64'(sz != 0));
        check("count",       bus.count,       64'(sz));
        check("outbuf_full", bus.outbuf_full, 64'(sz == DEPTH));
        check("in_pop",      bus.in_pop,      64'(exp_pop));
        if (sz != 0) check("dout", bus.dout, exp_q[0]);
`ifdef OUTBUF_ERR_EN
        check("err", bus.err, 64'(exp_err));
`endif
        @(posedge clk);
        if (rst) begin
            exp_q.delete();
            exp_err = 1'b0;
        end else begin
            if (g != 5'd0 && ($countones(g) != 1 || sz == DEPTH)) exp_err = 1'b1;
            if (sz != 0 && r) void'(exp_q.pop_front());
            if (exp_pop != 5'd0) begin
                flit = '0;
                for (int i = 0; i < 5; i++) if (g[i]) flit |= din[i];
                exp_q.push_back(flit);
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) drive_cycle(5'd0, r, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int k;
        n_checks = 0;
        n_pass   = 0;
        exp_err  = 1'b0;
        gnt      = 5'd0;
        ri       = 1'b1;
        reset    = 1'b1;
        for (int i = 0; i < 5; i++) din[i] = '0;

        // Reset then idle
        repeat (2) @(posedge clk);
        #1;
        idle(3, 1'b1);

        // Single flit from E
        din[2] = 64'hE0E0_0000_0000_0001;
        drive_cycle(5'b00100, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Fill and stall, then drain in order
        din[4] = 64'h1;
        din[3] = 64'h2;
        din[0] = 64'h3;
        drive_cycle(5'b10000, 1'b0, 1'b0);
        drive_cycle(5'b01000, 1'b0, 1'b0);
        drive_cycle(5'b00001, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Simultaneous push and pop at count=1
        din[0] = 64'h55;
        drive_cycle(5'b00001, 1'b0, 1'b0);
        din[1] = 64'hAA;
        drive_cycle(5'b00010, 1'b1, 1'b0);
        idle(2, 1'b1);

        // Streaming with wrap: PE, N, S, E, W repeated, values 1..10
        for (int i = 0; i < 10; i++) begin
            case (i % 5)
                0: k = 0;
                1: k = 4;
                2: k = 3;
                3: k = 2;
                default: k = 1;
            endcase
            din[k] = 64'(i + 1);
            drive_cycle(5'(1 << k), 1'b1, 1'b0);
        end
        idle(2, 1'b1);

        // Reset mid-operation with a coincident grant
        din[4] = 64'hDEAD;
        din[3] = 64'hBEEF;
        drive_cycle(5'b10000, 1'b0, 1'b0);
        drive_cycle(5'b01000, 1'b0, 1'b0);
        din[4] = 64'hBAD0;
        drive_cycle(5'b10000, 1'b0, 1'b1);
        idle(3, 1'b1);

`ifdef OUTBUF_ERR_EN
        // Illegal two-hot grant: sticky error until reset
        din[0] = 64'hF0;
        din[1] = 64'h0F;
        drive_cycle(5'b00011, 1'b1, 1'b0);
        idle(3, 1'b1);
        drive_cycle(5'b00000, 1'b1, 1'b1);
        idle(1, 1'b1);
`endif

        // Randomized phase (grants kept zero or one-hot)
        for (int i = 0; i < 400; i++) begin
            logic [4:0] g;
            logic       r;
            logic       rst;
            for (int j = 0; j < 5; j++) din[j] = {$urandom, $urandom};
            k   = $urandom_range(0, 6);
            g   = (k >= 5) ? 5'd0 : 5'(1 << k);
            r   = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 99) == 0);
            drive_cycle(g, r, rst);
        end
        idle(3, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
